transparency_fade_controller: RTL and testbench
===============================================

TRANSPARENCY_FADE_CONTROLLER -- requirements
Module: transparency_fade_controller

Interface
REQ-001 Parameter TRANSPARENCY_PRECISION, default 4: alpha resolution in bits; alpha range 0..2^P inclusive, P+1 bits wide.
REQ-002 Parameter RATE_WIDTH, default 8: width of the frames-per-step field.
REQ-003 Port clk, input, 1: the single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port frame_start, input, 1: single-cycle pulse at the start of each frame (vsync-derived).
REQ-006 Port cmd_valid, input, 1: fade command present.
REQ-007 Port cmd_ready, output, 1: controller can accept a command.
REQ-008 Port cmd_target, input, P+1: target src_a_proportion.
REQ-009 Port cmd_frames_per_step, input, RATE_WIDTH: frames between 1-LSB alpha steps.
REQ-010 Port cmd_instant, input, 1: jump to target at the next frame boundary.
REQ-011 Port src_a_proportion, output, P+1: registered alpha driven to the blend channels.
REQ-012 Port busy, output, 1: a fade is in progress.
REQ-013 Port done, output, 1: single-cycle pulse when a fade completes.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, DONE; cmd_ready SHALL be high only in IDLE; busy SHALL be high only in WAIT.
REQ-015 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both high; target, rate and instant SHALL be latched then.
REQ-016 A cmd_target above 2^P SHALL be saturated to 2^P at latch time; a rate of 0 SHALL be treated as 1.
REQ-017 On accept, if the latched target equals the current alpha, the FSM SHALL go to DONE; otherwise to WAIT with the frame counter cleared.
REQ-018 A frame_start coinciding with the accept cycle SHALL be ignored; counting starts the cycle after.
REQ-019 In WAIT, each frame_start SHALL increment the frame counter; on the frame_start where the counter equals rate-1, alpha SHALL move one LSB toward the target and the counter SHALL clear.
REQ-020 In WAIT with instant set, the first frame_start SHALL load alpha with the target directly.
REQ-021 src_a_proportion SHALL change only on the cycle after a frame_start, never mid-frame.
REQ-022 When alpha equals the target after an update, the FSM SHALL go to DONE; DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-023 Alpha SHALL never leave 0..2^P, and a step SHALL never overshoot the target.
REQ-024 Full-range fade latency SHALL be 2^P x rate frame_start pulses.

Reset
REQ-025 While rst is high: state IDLE, src_a_proportion = 2^P (full source A), frame counter 0, busy 0, done 0, cmd_ready 1.
REQ-026 Reset asserted mid-fade SHALL discard the fade with no done pulse.

Configuration
REQ-027 With macro TRANSPARENCY_FADE_ABORT_EN defined, input port abort (1 bit) SHALL exist: abort high in WAIT freezes alpha at its current value and goes to DONE (done pulses); abort in IDLE or DONE is ignored; abort has priority over a simultaneous frame_start step.
REQ-028 Without TRANSPARENCY_FADE_ABORT_EN, the abort port SHALL be absent and fades run to completion.

Structure
REQ-029 The state enum and an ALPHA_FULL(P) constant function (returns 2^P) SHALL live in shared package transparency_pkg.
REQ-030 The frame counter with its terminal-count compare SHALL be sub-module fade_frame_divider.

Verification
REQ-031 P=4; reset released; cmd target=0, rate=1 -> alpha steps 16,15,...,0 on 16 consecutive frame_starts; done pulses once; busy is low afterwards.
REQ-032 Alpha=0; cmd target=8, rate=3 -> alpha increments every third frame_start, reaches 8 after 24 frame_starts.
REQ-033 cmd target=31 (above 16), rate=0 -> treated as target=16, rate=1; alpha never exceeds 16.
REQ-034 Alpha=16; cmd target=4, instant=1, with frame_start in the accept cycle -> no change that cycle; alpha=4 after the next frame_start; done pulses.
REQ-035 cmd target equal to current alpha -> done pulses 2 cycles after accept; alpha unchanged; no frame_start needed.
REQ-036 rst pulsed mid-fade at alpha=9 -> alpha=16, IDLE, no done; with TRANSPARENCY_FADE_ABORT_EN, abort together with frame_start at alpha=9 -> alpha stays 9 and done pulses.

Source files
------------

// File: rtl/transparency_pkg.sv
// rtl/transparency_pkg.sv - shared state encoding and alpha helpers for the transparency fade controller
package transparency_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } fade_state_e;

    // Opaque source-A alpha for a given precision: 2^p.
    function automatic int unsigned ALPHA_FULL(input int unsigned p);
        return 32'd1 << p;
    endfunction

endpackage

// File: rtl/fade_frame_divider.sv
// rtl/fade_frame_divider.sv - frame counter that flags every rate-th frame_start tick
module fade_frame_divider #(
    parameter int RATE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  tick,
    input  logic [RATE_WIDTH-1:0] rate,
    output logic                  terminal
);

    logic [RATE_WIDTH-1:0] count_q;
    logic [RATE_WIDTH-1:0] count_d;

    // rate is never zero here; the controller maps 0 to 1 when it latches it.
    assign terminal = tick && (count_q == rate - RATE_WIDTH'(1));

    always_comb begin
        count_d = count_q;
        if (clear || terminal) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + RATE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/transparency_fade_controller.sv
// rtl/transparency_fade_controller.sv - frame-locked alpha fade FSM; optional abort input under TRANSPARENCY_FADE_ABORT_EN
module transparency_fade_controller
    import transparency_pkg::*;
#(
    parameter int TRANSPARENCY_PRECISION = 4,
    parameter int RATE_WIDTH             = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              frame_start,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [TRANSPARENCY_PRECISION:0]   cmd_target,
    input  logic [RATE_WIDTH-1:0]             cmd_frames_per_step,
    input  logic                              cmd_instant,
`ifdef TRANSPARENCY_FADE_ABORT_EN
    input  logic                              abort,
`endif
    output logic [TRANSPARENCY_PRECISION:0]   src_a_proportion,
    output logic                              busy,
    output logic                              done
);

    localparam int AW = TRANSPARENCY_PRECISION + 1;
    localparam logic [AW-1:0] FULL = AW'(ALPHA_FULL(TRANSPARENCY_PRECISION));

    fade_state_e           state_q, state_d;
    logic [AW-1:0]         alpha_q, alpha_d;
    logic [AW-1:0]         target_q;
    logic [RATE_WIDTH-1:0] rate_q;
    logic                  instant_q;
    logic                  done_q;

    logic                  accept;
    logic                  abort_w;
    logic                  step_tick;
    logic                  terminal;
    logic [AW-1:0]         target_sat;
    logic [AW-1:0]         alpha_step;

`ifdef TRANSPARENCY_FADE_ABORT_EN
    assign abort_w = abort && (state_q == WAIT);
`else
    assign abort_w = 1'b0;
`endif

    assign accept     = cmd_valid && (state_q == IDLE);
    assign target_sat = (cmd_target > FULL) ? FULL : cmd_target;
    // Abort wins over a coincident frame step, so the divider must not advance either.
    assign step_tick  = frame_start && (state_q == WAIT) && !abort_w;
    assign alpha_step = (alpha_q < target_q) ? alpha_q + AW'(1) : alpha_q - AW'(1);

    fade_frame_divider #(
        .RATE_WIDTH(RATE_WIDTH)
    ) u_divider (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .tick     (step_tick),
        .rate     (rate_q),
        .terminal (terminal)
    );

    always_comb begin
        state_d = state_q;
        alpha_d = alpha_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (target_sat == alpha_q) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (abort_w) begin
                    state_d = DONE;
                end else if (step_tick) begin
                    if (instant_q) begin
                        alpha_d = target_q;
                    end else if (terminal) begin
                        alpha_d = alpha_step;
                    end
                    if (alpha_d == target_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            alpha_q   <= FULL;
            target_q  <= FULL;
            rate_q    <= RATE_WIDTH'(1);
            instant_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            alpha_q <= alpha_d;
            done_q  <= (state_q == DONE);
            if (accept) begin
                target_q  <= target_sat;
                rate_q    <= (cmd_frames_per_step == '0) ? RATE_WIDTH'(1) : cmd_frames_per_step;
                instant_q <= cmd_instant;
            end
        end
    end

    assign cmd_ready        = (state_q == IDLE);
    assign busy             = (state_q == WAIT);
    assign done             = done_q;
    assign src_a_proportion = alpha_q;

endmodule

// File: tb/tb_transparency_fade_controller.sv
// tb/tb_transparency_fade_controller.sv - randomized self-checking bench with a frame-count alpha model
module tb_transparency_fade_controller;

    localparam int P    = 4;
    localparam int RW   = 8;
    localparam int FULL = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [P:0]    cmd_target;
    logic [RW-1:0] cmd_frames_per_step;
    logic          cmd_instant;
    logic [P:0]    src_a_proportion;
    logic          busy;
    logic          done;
`ifdef TRANSPARENCY_FADE_ABORT_EN
    logic          abort;
`endif

    int n_checks    = 0;
    int n_fail      = 0;
    int done_cnt    = 0;
    int model_alpha = FULL;

    transparency_fade_controller #(
        .TRANSPARENCY_PRECISION(P),
        .RATE_WIDTH            (RW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .frame_start         (frame_start),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_target          (cmd_target),
        .cmd_frames_per_step (cmd_frames_per_step),
        .cmd_instant         (cmd_instant),
`ifdef TRANSPARENCY_FADE_ABORT_EN
        .abort               (abort),
`endif
        .src_a_proportion    (src_a_proportion),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Alpha after n frame_starts: one LSB per 'rate' frames, never past the target.
    function automatic int exp_alpha(input int start, input int tgt, input int rate,
                                     input bit inst, input int n);
        int steps;
        if (n == 0) return start;
        if (inst) return tgt;
        steps = n / rate;
        if (tgt > start) return (tgt - start < steps) ? tgt : start + steps;
        return (start - tgt < steps) ? tgt : start - steps;
    endfunction

    task automatic issue(input int tgt, input int rate, input bit inst, input bit fs_acc);
        int guard;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("cmd_ready_before_accept", int'(cmd_ready), 1);
        cmd_valid           = 1'b1;
        cmd_target          = tgt[P:0];
        cmd_frames_per_step = rate[RW-1:0];
        cmd_instant         = inst;
        frame_start         = fs_acc;
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_instant = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic run_fade(input int tgt, input int rate, input bit inst, input bit fs_acc);
        int ts, rf, start, n, d0, e;
        ts    = (tgt > FULL) ? FULL : tgt;
        rf    = (rate == 0) ? 1 : rate;
        start = model_alpha;
        n     = 0;
        d0    = done_cnt;
        issue(tgt, rate, inst, fs_acc);
        #1;
        check_eq("alpha_after_accept", int'(src_a_proportion), start);
        check_eq("done_not_early", done_cnt, d0);
        if (ts == start) begin
            @(negedge clk); #1;
            check_eq("done_equal_target", done_cnt, d0 + 1);
            check_eq("alpha_equal_target", int'(src_a_proportion), start);
        end else begin
            check_eq("busy_in_fade", int'(busy), 1);
            check_eq("ready_low_in_fade", int'(cmd_ready), 0);
            while (exp_alpha(start, ts, rf, inst, n) != ts && n < 300) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    check_eq("alpha_midframe", int'(src_a_proportion), exp_alpha(start, ts, rf, inst, n));
                end
                pulse_frame();
                n++;
                e = exp_alpha(start, ts, rf, inst, n);
                check_eq("alpha_step", int'(src_a_proportion), e);
                if (e != ts) check_eq("busy_mid", int'(busy), 1);
            end
            check_eq("frame_latency", n, inst ? 1 : ((ts > start) ? ts - start : start - ts) * rf);
            @(negedge clk); #1;
            check_eq("done_pulse", done_cnt, d0 + 1);
            check_eq("busy_after", int'(busy), 0);
        end
        @(negedge clk); #1;
        check_eq("done_single", done_cnt, d0 + 1);
        check_eq("ready_after", int'(cmd_ready), 1);
        check_eq("alpha_final", int'(src_a_proportion), ts);
        model_alpha = ts;
    endtask

    initial begin
        int d0;
        rst                 = 1'b1;
        frame_start         = 1'b0;
        cmd_valid           = 1'b0;
        cmd_target          = '0;
        cmd_frames_per_step = '0;
        cmd_instant         = 1'b0;
`ifdef TRANSPARENCY_FADE_ABORT_EN
        abort               = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_alpha", int'(src_a_proportion), FULL);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_ready", int'(cmd_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        run_fade(0, 1, 1'b0, 1'b0);
        run_fade(8, 3, 1'b0, 1'b0);
        run_fade(31, 0, 1'b0, 1'b0);
        run_fade(4, 1, 1'b1, 1'b1);
        run_fade(4, 2, 1'b0, 1'b0);

        // Reset in the middle of a 16->0 fade at alpha 9.
        run_fade(16, 1, 1'b1, 1'b0);
        issue(0, 1, 1'b0, 1'b0);
        repeat (7) pulse_frame();
        check_eq("pre_reset_alpha", int'(src_a_proportion), 9);
        d0  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check_eq("midreset_alpha", int'(src_a_proportion), FULL);
        check_eq("midreset_busy", int'(busy), 0);
        check_eq("midreset_ready", int'(cmd_ready), 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("midreset_no_done", done_cnt, d0);
        model_alpha = FULL;

`ifdef TRANSPARENCY_FADE_ABORT_EN
        d0    = done_cnt;
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        #1;
        check_eq("abort_idle_ignored", done_cnt, d0);
        issue(0, 1, 1'b0, 1'b0);
        repeat (7) pulse_frame();
        abort       = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        abort       = 1'b0;
        frame_start = 1'b0;
        check_eq("abort_alpha_frozen", int'(src_a_proportion), 9);
        @(negedge clk); #1;
        check_eq("abort_done", done_cnt, d0 + 1);
        check_eq("abort_alpha_hold", int'(src_a_proportion), 9);
        @(negedge clk);
        model_alpha = 9;
`endif

        for (int i = 0; i < 12; i++) begin
            run_fade(int'($urandom_range(0, 31)), int'($urandom_range(0, 4)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
